mem_core_parser: RTL and testbench

MEM_CORE_PARSER -- requirements
Module: mem_core_parser

---
 rtl/mem_core_parser.sv | 47 ++++
 tb/tb_mem_core_parser.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_core_parser.sv
// Single-port write-first synchronous RAM with registered read port.
// Define MEM_INIT_PATTERN_EN to preload a Life-grid glider in words 1..3.
module mem_core_parser #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024
) (
   input  logic                  clka,
   input  logic                  rsta_n,
   input  logic                  wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] dina,
   output logic [DATA_WIDTH-1:0] douta
);

   localparam logic [DATA_WIDTH-1:0] W_ROW1 = DATA_WIDTH'(4'h4);
   localparam logic [DATA_WIDTH-1:0] W_ROW2 = DATA_WIDTH'(4'h8);
   localparam logic [DATA_WIDTH-1:0] W_ROW3 = DATA_WIDTH'(4'hE);

   // Array contents are set once at configuration; reset never reloads them.
`ifdef MEM_INIT_PATTERN_EN
   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{
      1       : W_ROW1,
      2       : W_ROW2,
      3       : W_ROW3,
      default : '0
   };
`else
   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};
`endif

   logic [DATA_WIDTH-1:0] r_douta;

   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         r_douta <= '0;
      end else if (wea) begin
         r_mem[addra] <= dina;
         r_douta      <= dina;
      end else begin
         r_douta <= r_mem[addra];
      end
   end

   assign douta = r_douta;

endmodule

// File: tb/tb_mem_core_parser.sv
// Scoreboard bench for mem_core_parser: expected words are queued at drive
// time and compared one cycle later against douta.
module tb_mem_core_parser;

   localparam int DW = 128;
   localparam int AW = 10;
   localparam int DP = 1024;

   logic          clka;
   logic          rsta_n;
   logic          wea;
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic [DW-1:0] douta;

   typedef struct {
      logic [DW-1:0] exp;
      string         tag;
   } sb_t;

   sb_t           q[$];
   logic [DW-1:0] mdl [0:DP-1];
   int            checks   = 0;
   int            failures = 0;

   mem_core_parser #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH     (DP)
   ) dut (
      .clka  (clka),
      .rsta_n(rsta_n),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic op(input logic rn, input logic we, input int unsigned a,
                     input logic [DW-1:0] d, input string tag);
      sb_t e;
      @(negedge clka);
      rsta_n = rn;
      wea    = we;
      addra  = a[AW-1:0];
      dina   = d;
      if (!rn) begin
         e.exp = '0;
      end else if (we) begin
         mdl[a] = d;
         e.exp  = d;
      end else begin
         e.exp = mdl[a];
      end
      e.tag = tag;
      q.push_back(e);
   endtask

   always @(posedge clka) begin
      sb_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk(e.tag, douta, e.exp);
      end
   end

   initial begin
      logic [DW-1:0] d;
      int unsigned   a;
      for (int i = 0; i < DP; i++) mdl[i] = '0;
`ifdef MEM_INIT_PATTERN_EN
      mdl[1] = 128'h4;
      mdl[2] = 128'h8;
      mdl[3] = 128'hE;
`endif
      rsta_n = 1'b0;
      wea    = 1'b0;
      addra  = '0;
      dina   = '0;

      op(1'b0, 1'b0, 0, '0, "rst_rd0");
      op(1'b0, 1'b0, 1, '0, "rst_rd1");
      for (int i = 0; i < 6; i++) op(1'b1, 1'b0, i, '0, "init_rd");
`ifdef MEM_INIT_PATTERN_EN
      op(1'b1, 1'b0, 3, '0, "glider_row3");
      if (mdl[3] !== 128'h0E) chk("glider_mdl", mdl[3], 128'h0E);
`endif

      op(1'b1, 1'b1, 41, 128'hDEADBEEF_0123, "wr41");
      op(1'b1, 1'b0, 41, '0, "rd41");
      op(1'b1, 1'b1, 7, 128'hA5, "wr_first7");
      op(1'b1, 1'b0, 7, '0, "rd7");

      op(1'b1, 1'b1, 1023, {4{32'hCAFE_1023}}, "wr1023");
      op(1'b1, 1'b1, 0, {4{32'h0BAD_0000}}, "wr0");
      op(1'b1, 1'b0, 1023, '0, "rd1023");
      op(1'b1, 1'b0, 0, '0, "rd0_wrap");
      op(1'b1, 1'b0, 512, '0, "rd512");

      op(1'b1, 1'b1, 5, 128'h5555_AAAA, "wr5");
      op(1'b0, 1'b1, 5, 128'hFF, "rst_wr5");
      op(1'b0, 1'b0, 5, '0, "rst_hold");
      op(1'b1, 1'b0, 5, '0, "rd5_kept");
      op(1'b1, 1'b0, 3, '0, "rd3_noreload");
      op(1'b1, 1'b1, 9, {DW{1'b1}}, "wr_ones");
      op(1'b1, 1'b0, 9, '0, "rd_ones");

      for (int i = 0; i < 60; i++) begin
         a = (i % 4 == 0) ? 32'(1023 - (i % 2)) : $urandom_range(0, 63);
         d = {$urandom, $urandom, $urandom, $urandom};
         op(1'b1, ($urandom_range(0, 1) == 1), a, d, "rand");
      end

      @(negedge clka);
      wea = 1'b0;
      @(negedge clka);
      chk("sb_drain", DW'(q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
